// File: rtl/vdp_cartridge_slot_io.sv
// rtl/vdp_cartridge_slot_io.sv - MSX slot I/O front end: VDP ports 0..3, register/palette/VRAM forwarding.
// Slot strobes are resynchronised; a one-deep defer slot plus /WAIT keeps VRAM traffic lossless.
module vdp_cartridge_slot_io #(
  parameter logic [7:0] IO_BASE = 8'h88
) (
  input  logic        clk14m,
  input  logic        slot_reset_n,
  input  logic        slot_iorq_n,
  input  logic        slot_rd_n,
  input  logic        slot_wr_n,
  input  logic [7:0]  slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_data_dir,
  output logic        busdir,
  output logic        oe_n,
  output logic        slot_wait,
  output logic        slot_intr,
  input  logic        init_busy,
  input  logic        vsync_pulse,
  input  logic        cmd_tr,
  input  logic        cmd_ce,
  input  logic [7:0]  cmd_clr,
  output logic        reg_wr,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  output logic        pal_wr,
  output logic [3:0]  pal_num,
  output logic [15:0] pal_data,
  output logic        vram_valid,
  output logic        vram_write,
  output logic [16:0] vram_addr,
  output logic [7:0]  vram_wdata,
  input  logic        vram_ready,
  input  logic        vram_rdata_en,
  input  logic [7:0]  vram_rdata
);

  logic [1:0]  iorq_q, rd_q, wr_q;
  logic [7:0]  a_q1, a_q2, d_q1, d_q2;
  logic        sel, wr_act, rd_act, wr_prev, rd_prev, wr_ev, rd_end;
  logic [1:0]  port, rd_port;

  logic        phase, pal_phase, f_flag, r1_ie0, r17_aii, rd_pending;
  logic [7:0]  latch, pal_latch, prefetch;
  logic [2:0]  r14;
  logic [3:0]  r15, r16;
  logic [5:0]  r17_num;
  logic [16:0] addr;

  logic        defer_valid, defer_write;
  logic [16:0] defer_addr;
  logic [7:0]  defer_data;

  logic        rw_fire, req_fire, req_write, free_core, stall;
  logic [5:0]  rw_num;
  logic [7:0]  rw_data, req_data, status, rd_mux;
  logic [16:0] req_addr, set_addr;

  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      iorq_q <= 2'b11;
      rd_q   <= 2'b11;
      wr_q   <= 2'b11;
      a_q1   <= 8'h00;
      a_q2   <= 8'h00;
      d_q1   <= 8'h00;
      d_q2   <= 8'h00;
    end else begin
      iorq_q <= {iorq_q[0], slot_iorq_n};
      rd_q   <= {rd_q[0], slot_rd_n};
      wr_q   <= {wr_q[0], slot_wr_n};
      a_q1   <= slot_a;
      a_q2   <= a_q1;
      d_q1   <= slot_d_in;
      d_q2   <= d_q1;
    end
  end

  assign sel      = !iorq_q[1] && (a_q2[7:2] == IO_BASE[7:2]);
  assign port     = a_q2[1:0];
  assign wr_act   = sel && !wr_q[1];
  assign rd_act   = sel && !rd_q[1];
  assign wr_ev    = wr_act && !wr_prev;
  assign rd_end   = rd_prev && !rd_act;
  assign set_addr = {r14, d_q2[5:0], latch};

  always_comb begin
    rw_fire   = 1'b0;
    rw_num    = 6'd0;
    rw_data   = 8'h00;
    req_fire  = 1'b0;
    req_write = 1'b0;
    req_addr  = addr;
    req_data  = d_q2;
    if (wr_ev) begin
      case (port)
        2'd0: begin
          req_fire  = 1'b1;
          req_write = 1'b1;
        end
        2'd1: begin
          if (phase && d_q2[7]) begin
            rw_fire = 1'b1;
            rw_num  = d_q2[5:0];
            rw_data = latch;
          end else if (phase && !d_q2[6]) begin
            req_fire = 1'b1;
            req_addr = set_addr;
          end
        end
        2'd3: begin
          rw_fire = 1'b1;
          rw_num  = r17_num;
          rw_data = d_q2;
        end
        default: ;
      endcase
    end else if (rd_end && rd_port == 2'd0) begin
      req_fire = 1'b1;
    end
  end

  always_comb begin
    case (r15)
      4'd0:    status = {f_flag, 7'b0};
      4'd2:    status = {cmd_tr, 6'b0, cmd_ce};
      4'd7:    status = cmd_clr;
      default: status = 8'h00;
    endcase
    case (port)
      2'd0:    rd_mux = prefetch;
      2'd1:    rd_mux = status;
      default: rd_mux = 8'h00;
    endcase
  end

  // A request may issue on the same edge the previous one is accepted or its data returns.
  assign free_core = (!vram_valid || vram_ready) && (!rd_pending || vram_rdata_en);
  assign stall     = sel && port == 2'd0 && (rd_act || wr_act) &&
                     (vram_valid || rd_pending || defer_valid || req_fire);

  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      wr_prev       <= 1'b0;
      rd_prev       <= 1'b0;
      rd_port       <= 2'd0;
      slot_d_out    <= 8'h00;
      slot_data_dir <= 1'b0;
      oe_n          <= 1'b1;
      slot_wait     <= 1'b1;
      phase         <= 1'b0;
      latch         <= 8'h00;
      addr          <= 17'd0;
      pal_phase     <= 1'b0;
      pal_latch     <= 8'h00;
      pal_wr        <= 1'b0;
      pal_num       <= 4'd0;
      pal_data      <= 16'h0000;
      reg_wr        <= 1'b0;
      reg_num       <= 6'd0;
      reg_data      <= 8'h00;
      r1_ie0        <= 1'b0;
      r14           <= 3'd0;
      r15           <= 4'd0;
      r16           <= 4'd0;
      r17_aii       <= 1'b0;
      r17_num       <= 6'd0;
      f_flag        <= 1'b0;
    end else begin
      wr_prev       <= wr_act;
      rd_prev       <= rd_act;
      oe_n          <= 1'b0;
      slot_wait     <= init_busy || stall;
      slot_data_dir <= rd_act;
      slot_d_out    <= rd_act ? rd_mux : 8'h00;
      pal_wr        <= 1'b0;
      reg_wr        <= rw_fire;
      if (rd_act) rd_port <= port;
      if (rw_fire) begin
        reg_num  <= rw_num;
        reg_data <= rw_data;
      end

      if (wr_ev && port == 2'd1) begin
        phase <= !phase;
        if (!phase) latch <= d_q2;
        else if (!d_q2[7]) addr <= set_addr + {16'd0, !d_q2[6]};
      end
      if (rd_end && rd_port == 2'd1) phase <= 1'b0;
      if ((wr_ev && port == 2'd0) || (rd_end && rd_port == 2'd0)) addr <= addr + 17'd1;

      if (wr_ev && port == 2'd2) begin
        pal_phase <= !pal_phase;
        if (!pal_phase) begin
          pal_latch <= d_q2;
        end else begin
          pal_wr   <= 1'b1;
          pal_num  <= r16;
          pal_data <= {pal_latch, d_q2};
          r16      <= r16 + 4'd1;
        end
      end
      if (wr_ev && port == 2'd3 && !r17_aii) r17_num <= r17_num + 6'd1;

      // Explicit register writes land after the auto-increments so they take priority.
      if (rw_fire) begin
        case (rw_num)
          6'd1:  r1_ie0 <= rw_data[5];
          6'd14: r14    <= rw_data[2:0];
          6'd15: r15    <= rw_data[3:0];
          6'd16: r16    <= rw_data[3:0];
          6'd17: begin
            r17_aii <= rw_data[7];
            r17_num <= rw_data[5:0];
          end
          default: ;
        endcase
      end

      if (vsync_pulse) f_flag <= 1'b1;
      else if (rd_end && rd_port == 2'd1 && r15 == 4'd0) f_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      vram_valid  <= 1'b0;
      vram_write  <= 1'b0;
      vram_addr   <= 17'd0;
      vram_wdata  <= 8'h00;
      rd_pending  <= 1'b0;
      prefetch    <= 8'h00;
      defer_valid <= 1'b0;
      defer_write <= 1'b0;
      defer_addr  <= 17'd0;
      defer_data  <= 8'h00;
    end else begin
      if (vram_valid && vram_ready) vram_valid <= 1'b0;
      if (vram_rdata_en) begin
        rd_pending <= 1'b0;
        prefetch   <= vram_rdata;
      end
      if (defer_valid && free_core) begin
        vram_valid  <= 1'b1;
        vram_write  <= defer_write;
        vram_addr   <= defer_addr;
        vram_wdata  <= defer_data;
        if (!defer_write) rd_pending <= 1'b1;
        defer_valid <= req_fire;
        defer_write <= req_write;
        defer_addr  <= req_addr;
        defer_data  <= req_data;
      end else if (req_fire && free_core) begin
        vram_valid <= 1'b1;
        vram_write <= req_write;
        vram_addr  <= req_addr;
        vram_wdata <= req_data;
        if (!req_write) rd_pending <= 1'b1;
      end else if (req_fire) begin
        defer_valid <= 1'b1;
        defer_write <= req_write;
        defer_addr  <= req_addr;
        defer_data  <= req_data;
      end
    end
  end

  assign busdir    = slot_data_dir;
  assign slot_intr = f_flag && r1_ie0;

endmodule

// File: tb/tb_vdp_cartridge_slot_io.sv
// tb/tb_vdp_cartridge_slot_io.sv - directed bench for the VDP cartridge slot I/O front end.
module tb_vdp_cartridge_slot_io;

  localparam logic [7:0] P0 = 8'h88;
  localparam logic [7:0] P1 = 8'h89;
  localparam logic [7:0] P2 = 8'h8A;
  localparam logic [7:0] P3 = 8'h8B;

  logic        clk14m = 1'b0;
  logic        slot_reset_n = 1'b0;
  logic        slot_iorq_n = 1'b1, slot_rd_n = 1'b1, slot_wr_n = 1'b1;
  logic [7:0]  slot_a = 8'h00, slot_d_in = 8'h00;
  logic [7:0]  slot_d_out;
  logic        slot_data_dir, busdir, oe_n, slot_wait, slot_intr;
  logic        init_busy = 1'b1, vsync_pulse = 1'b0, cmd_tr = 1'b0, cmd_ce = 1'b0;
  logic [7:0]  cmd_clr = 8'h00;
  logic        reg_wr, pal_wr, vram_valid, vram_write;
  logic [5:0]  reg_num;
  logic [7:0]  reg_data, vram_wdata;
  logic [3:0]  pal_num;
  logic [15:0] pal_data;
  logic [16:0] vram_addr;
  logic        vram_ready = 1'b0, vram_rdata_en = 1'b0;
  logic [7:0]  vram_rdata = 8'h00;

  vdp_cartridge_slot_io #(.IO_BASE(8'h88)) dut (
    .clk14m(clk14m), .slot_reset_n(slot_reset_n), .slot_iorq_n(slot_iorq_n),
    .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n), .slot_a(slot_a), .slot_d_in(slot_d_in),
    .slot_d_out(slot_d_out), .slot_data_dir(slot_data_dir), .busdir(busdir), .oe_n(oe_n),
    .slot_wait(slot_wait), .slot_intr(slot_intr), .init_busy(init_busy),
    .vsync_pulse(vsync_pulse), .cmd_tr(cmd_tr), .cmd_ce(cmd_ce), .cmd_clr(cmd_clr),
    .reg_wr(reg_wr), .reg_num(reg_num), .reg_data(reg_data), .pal_wr(pal_wr),
    .pal_num(pal_num), .pal_data(pal_data), .vram_valid(vram_valid), .vram_write(vram_write),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ready(vram_ready),
    .vram_rdata_en(vram_rdata_en), .vram_rdata(vram_rdata)
  );

  always #5 clk14m = ~clk14m;

  typedef struct { logic [5:0] num; logic [7:0] data; } rw_t;
  typedef struct { logic w; logic [16:0] a; logic [7:0] d; } vreq_t;
  typedef struct { logic [7:0] port; logic [7:0] data; int n_rw; logic [5:0] num; logic [7:0] rdat; } vec_t;

  rw_t    rw_q[$];
  rw_t    pal_q[$];
  vreq_t  vq[$];
  logic [15:0] pal_dq[$];
  int     checks = 0, errors = 0;
  int     vcnt = 0, rcnt = 0;
  logic [7:0] rval;

  function automatic logic [7:0] mem_val(input logic [16:0] a);
    return (a == 17'd0) ? 8'h5A : (a[7:0] + 8'h30);
  endfunction

  always @(negedge clk14m) begin
    if (reg_wr) rw_q.push_back('{reg_num, reg_data});
    if (pal_wr) begin
      pal_q.push_back('{{2'b00, pal_num}, 8'h00});
      pal_dq.push_back(pal_data);
    end
  end

  // Memory-side responder: accepts after a short delay, returns read data three cycles later.
  always @(negedge clk14m) begin
    vram_rdata_en = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        vram_rdata_en = 1'b1;
        vram_rdata = rval;
      end
    end
    if (vram_ready) begin
      vram_ready = 1'b0;
      vcnt = 0;
    end else if (vram_valid) begin
      if (vcnt >= 2) begin
        vq.push_back('{vram_write, vram_addr, vram_wdata});
        vram_ready = 1'b1;
        if (!vram_write) begin
          rcnt = 3;
          rval = mem_val(vram_addr);
        end
      end else begin
        vcnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk14m);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (slot_wait && n < 300) begin
      tick(1);
      n++;
    end
    if (slot_wait) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: slot_wait still 1 expected 0");
    end
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    slot_a = a;
    slot_d_in = d;
    tick(1);
    slot_iorq_n = 1'b0;
    slot_wr_n = 1'b0;
    tick(8);
    wait_ready();
    slot_wr_n = 1'b1;
    slot_iorq_n = 1'b1;
    tick(6);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic dir);
    slot_a = a;
    tick(1);
    slot_iorq_n = 1'b0;
    slot_rd_n = 1'b0;
    tick(8);
    wait_ready();
    tick(2);
    d = slot_d_out;
    dir = slot_data_dir;
    slot_rd_n = 1'b1;
    slot_iorq_n = 1'b1;
    tick(6);
  endtask

  vec_t vecs[11];
  logic [7:0] rd;
  logic dir;
  int base, vb;

  initial begin
    vecs[0]  = '{P1, 8'h06, 0, 6'd0,  8'h00};
    vecs[1]  = '{P1, 8'h80, 1, 6'd0,  8'h06};
    vecs[2]  = '{P1, 8'h40, 0, 6'd0,  8'h00};
    vecs[3]  = '{P1, 8'h81, 1, 6'd1,  8'h40};
    vecs[4]  = '{P1, 8'hAC, 0, 6'd0,  8'h00};
    vecs[5]  = '{P1, 8'h91, 1, 6'd17, 8'hAC};
    vecs[6]  = '{P3, 8'h01, 1, 6'd44, 8'h01};
    vecs[7]  = '{P3, 8'h02, 1, 6'd44, 8'h02};
    vecs[8]  = '{P3, 8'h03, 1, 6'd44, 8'h03};
    vecs[9]  = '{P1, 8'h24, 0, 6'd0,  8'h00};
    vecs[10] = '{P1, 8'h91, 1, 6'd17, 8'h24};

    tick(3);
    chk("rst_d_out", slot_d_out, 8'h00);
    chk("rst_dir", {slot_data_dir, busdir}, 2'b00);
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_wait", slot_wait, 1'b1);
    chk("rst_intr", slot_intr, 1'b0);
    chk("rst_strobes", {reg_wr, pal_wr, vram_valid}, 3'b000);
    slot_reset_n = 1'b1;
    tick(1);
    chk("oe_n_after_reset", oe_n, 1'b0);
    tick(45);
    chk("wait_init_busy", slot_wait, 1'b1);
    init_busy = 1'b0;
    tick(3);
    chk("wait_init_done", slot_wait, 1'b0);

    for (int i = 0; i < 11; i++) begin
      base = rw_q.size();
      io_write(vecs[i].port, vecs[i].data);
      chk($sformatf("vec%0d_rw_count", i), rw_q.size() - base, vecs[i].n_rw);
      if (vecs[i].n_rw == 1 && rw_q.size() > base) begin
        chk($sformatf("vec%0d_num", i), rw_q[base].num, vecs[i].num);
        chk($sformatf("vec%0d_data", i), rw_q[base].data, vecs[i].rdat);
      end
    end

    base = rw_q.size();
    for (int i = 0; i < 11; i++) io_write(P3, 8'h10 + 8'(i));
    chk("aii_count", rw_q.size() - base, 11);
    for (int i = 0; i < 11 && base + i < rw_q.size(); i++)
      chk($sformatf("aii_%0d", i), {rw_q[base+i].num, rw_q[base+i].data},
          {6'(36 + i), 8'(8'h10 + i)});

    io_write(P1, 8'h00); io_write(P1, 8'h8E);
    io_write(P1, 8'h00); io_write(P1, 8'h40);
    vb = vq.size();
    for (int i = 0; i < 256; i++) io_write(P0, 8'(i));
    chk("vwr_count", vq.size() - vb, 256);
    for (int i = 0; i < 256 && vb + i < vq.size(); i++)
      chk($sformatf("vwr_%0d", i), {vq[vb+i].w, vq[vb+i].a, vq[vb+i].d}, {1'b1, 17'(i), 8'(i)});

    io_write(P1, 8'h07); io_write(P1, 8'h8E);
    io_write(P1, 8'hFF); io_write(P1, 8'h7F);
    vb = vq.size();
    io_write(P0, 8'hAA);
    io_write(P0, 8'h55);
    chk("wrap_count", vq.size() - vb, 2);
    if (vq.size() >= vb + 2) begin
      chk("wrap_top", {vq[vb].w, vq[vb].a, vq[vb].d}, {1'b1, 17'h1FFFF, 8'hAA});
      chk("wrap_zero", {vq[vb+1].w, vq[vb+1].a, vq[vb+1].d}, {1'b1, 17'h00000, 8'h55});
    end

    io_write(P1, 8'h02); io_write(P1, 8'h8F);
    cmd_tr = 1'b1; cmd_ce = 1'b1;
    io_read(P1, rd, dir);
    chk("s2_set", rd, 8'h81);
    chk("s2_dir", dir, 1'b1);
    cmd_tr = 1'b0; cmd_ce = 1'b0;
    io_read(P1, rd, dir);
    chk("s2_clear", rd, 8'h00);
    io_write(P1, 8'h07); io_write(P1, 8'h8F);
    cmd_clr = 8'h3C;
    io_read(P1, rd, dir);
    chk("s7", rd, 8'h3C);

    io_write(P1, 8'h20); io_write(P1, 8'h81);
    io_write(P1, 8'h00); io_write(P1, 8'h8F);
    chk("intr_idle", slot_intr, 1'b0);
    vsync_pulse = 1'b1;
    tick(1);
    vsync_pulse = 1'b0;
    tick(1);
    chk("intr_set", slot_intr, 1'b1);
    io_read(P1, rd, dir);
    chk("s0_f", rd, 8'h80);
    chk("intr_cleared", slot_intr, 1'b0);
    io_read(P1, rd, dir);
    chk("s0_after", rd, 8'h00);

    io_write(P1, 8'h05); io_write(P1, 8'h90);
    base = pal_q.size();
    io_write(P2, 8'h12); io_write(P2, 8'h34);
    io_write(P2, 8'h56); io_write(P2, 8'h07);
    chk("pal_count", pal_q.size() - base, 2);
    if (pal_q.size() >= base + 2) begin
      chk("pal0", {pal_q[base].num[3:0], pal_dq[base]}, {4'd5, 16'h1234});
      chk("pal1", {pal_q[base+1].num[3:0], pal_dq[base+1]}, {4'd6, 16'h5607});
    end

    io_write(P1, 8'h00); io_write(P1, 8'h8E);
    vb = vq.size();
    io_write(P1, 8'h00); io_write(P1, 8'h00);
    tick(10);
    io_read(P0, rd, dir);
    chk("prefetch0", rd, 8'h5A);
    io_read(P0, rd, dir);
    chk("prefetch1", rd, 8'h31);
    chk("vrd_count", vq.size() - vb, 3);
    for (int i = 0; i < 3 && vb + i < vq.size(); i++)
      chk($sformatf("vrd_%0d", i), {vq[vb+i].w, vq[vb+i].a}, {1'b0, 17'(i)});

    base = rw_q.size();
    vb = vq.size();
    io_write(8'h8C, 8'h81);
    io_read(8'h8C, rd, dir);
    chk("unused_no_effect", {32'(rw_q.size() - base), 32'(vq.size() - vb)} == 64'd0, 1'b1);
    chk("unused_no_drive", dir, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
